sobel_grad_unit: RTL and testbench
==================================

# sobel_grad_unit

Parametrised Sobel gradient engine that replaces the single-axis squared-gradient lane. Accepts one full 3x3 RGB window per handshake and computes luminance, Gx and Gy in one pipeline. Emits a runtime-selectable gradient measure with valid/ready flow control and an output sample counter. Sits between the line-buffer window generator and the edge thresholding / display stage.

## Interface
- CH_W, 8: bits per colour channel.
- CNT_W, 16: width of the output sample counter.
- Derived, not overridable:
  - Y_W = CH_W+4
  - G_W = Y_W+3 (signed)
  - MAG_W = 2*CH_W+13 (29 at default)
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_win  in  27*CH_W  3x3 window, flattened.
  - Pixel k = row*3+col, bits [k*3*CH_W +: 3*CH_W].
  - Each pixel is {R,G,B}, R in MSBs.
- in_mode  in  2  result select, sampled with the window.
- in_valid  in  1  window valid.
- in_ready  out  1  unit accepts the window this cycle.
- data_out  out  MAG_W  selected result, zero-extended.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts.
- out_count  out  CNT_W  number of completed output handshakes since reset.

## Operation
- **Stage 1 (luma):** Y_k = 5R+9G+2B per pixel, unsigned Y_W bits.
  - Stage 1 registers all nine Y values and the mode.
- **Stage 2 (gradients), signed G_W arithmetic:**
  - Gx = (Y2+2Y5+Y8) - (Y0+2Y3+Y6)
  - Gy = (Y6+2Y7+Y8) - (Y0+2Y1+Y2)
  - Y4 is unused.
- **Stage 3 (result), per registered mode:**
  - 00: Gx²
  - 01: Gy²
  - 10: Gx²+Gy²
  - 11: |Gx|+|Gy|, zero-extended to MAG_W
  - No truncation or saturation. MAG_W holds the worst case 2*(16*(2^CH_W-1)*4)² exactly.
- **Flow control:**
  - Each stage has a valid bit.
  - Global advance = !s3_valid || out_ready.
  - in_ready = advance.
  - When advance=0, every stage register holds, including valid bits.
  - Bubbles propagate as valid=0; they are not compressed.
- **out_count:** increments on each cycle with out_valid && out_ready. It wraps from 2^CNT_W-1 to 0.
- **Reset (reset=0 at a clock edge):**
  - All valid bits, data_out and out_count go to 0.
  - Any in-flight windows are discarded.
  - in_ready is 1 in the cycle after reset is released.
- in_mode is captured per window, so a mode change never affects windows already in flight.

## Timing
- Latency: a window accepted in cycle c (in_valid && in_ready) presents out_valid=1 in cycle c+3 if out_ready was held 1.
- Throughput: one window per clock with out_ready=1.
- While out_valid=1 and out_ready=0:
  - data_out, out_valid and out_count stay stable.
  - in_ready=0.
- out_ready rising releases the whole pipeline in the same cycle; there is no extra bubble.
- out_valid never deasserts without a handshake, except on reset.
- All outputs are registered except in_ready, which is combinational from s3_valid and out_ready.

## Configuration
- SOBEL_EDGE_THRESH_EN defined:
  - Adds input port thresh [MAG_W-1:0] and output port edge_out [1].
  - edge_out = (stage-3 result >= thresh), registered alongside data_out, using thresh sampled at stage-3 load.
  - edge_out resets to 0 and holds under stall like data_out.
- SOBEL_EDGE_THRESH_EN undefined: the thresh and edge_out ports do not exist and there is no comparator logic.

## Test plan
- Uniform window (all pixels 128,128,128), each mode -> data_out=0 in all four modes, 3 cycles after acceptance.
- Left column black, right column white (255,255,255):
  - mode 00 -> 266,342,400
  - mode 01 -> 0
  - mode 10 -> 266,342,400
  - mode 11 -> 16,320
- Mirror image (left column white, right column black):
  - mode 00 -> 266,342,400 (Gx=-16,320)
  - mode 11 -> 16,320
- Backpressure: stream 6 distinct windows, hold out_ready=0 for cycles 4-8 -> in_ready=0 and data_out stable during the stall, then all 6 results arrive in order with no loss or duplication, and out_count=6.
- Reset mid-stream: assert reset with 3 windows in flight -> next cycle out_valid=0 and out_count=0, and no stale result ever appears afterwards.
- CNT_W=4, 17 output handshakes -> out_count reads 15 then 0 then 1. With SOBEL_EDGE_THRESH_EN and thresh=1000, mode 11 edge window -> edge_out=1; uniform window -> edge_out=0.

Source files
------------

// File: rtl/sobel_grad_unit.sv
// rtl/sobel_grad_unit.sv - 3-stage Sobel gradient engine (luma, Gx/Gy, selected measure); optional SOBEL_EDGE_THRESH_EN adds thresh/edge_out
module sobel_grad_unit #(
   parameter  int CH_W  = 8,
   parameter  int CNT_W = 16,
   localparam int Y_W   = CH_W + 4,
   localparam int G_W   = Y_W + 3,
   localparam int MAG_W = 2 * CH_W + 13
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [27*CH_W-1:0]  in_win,
   input  logic [1:0]          in_mode,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [MAG_W-1:0]    data_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CNT_W-1:0]    out_count
`ifdef SOBEL_EDGE_THRESH_EN
  ,input  logic [MAG_W-1:0]    thresh,
   output logic                edge_out
`endif
);

   localparam int PIX_W = 3 * CH_W;

   // Y = 5R + 9G + 2B built from shifts; max 16*(2^CH_W-1) fits Y_W bits
   function automatic logic [Y_W-1:0] luma(input logic [PIX_W-1:0] p);
      logic [Y_W-1:0] r, g, b;
      r = Y_W'(p[PIX_W-1 -: CH_W]);
      g = Y_W'(p[2*CH_W-1 -: CH_W]);
      b = Y_W'(p[CH_W-1:0]);
      return (r << 2) + r + (g << 3) + g + (b << 1);
   endfunction

   logic                 advance;
   logic                 s1_valid, s2_valid;
   logic [1:0]           s1_mode, s2_mode;
   logic [Y_W-1:0]       s1_y [9];
   logic signed [G_W-1:0] s2_gx, s2_gy;
   logic signed [G_W-1:0] ext_y [9];
   logic signed [G_W-1:0] gx_c, gy_c;
   logic [G_W-1:0]       abs_x, abs_y;
   logic [MAG_W-1:0]     sq_x, sq_y, res;
   logic                 unused_center;

   // The whole pipeline moves together; a stalled output freezes every stage
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Centre luma carries zero weight in both kernels
   assign unused_center = ^s1_y[4];

   // Stage 1: per-pixel luminance and the window's mode
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid <= 1'b0;
      end else if (advance) begin
         s1_valid <= in_valid;
         s1_mode  <= in_mode;
         for (int k = 0; k < 9; k++) begin
            s1_y[k] <= luma(in_win[k*PIX_W +: PIX_W]);
         end
      end
   end

   // Signed horizontal and vertical Sobel kernels on the registered lumas
   always_comb begin
      for (int k = 0; k < 9; k++) begin
         ext_y[k] = $signed({3'b000, s1_y[k]});
      end
      gx_c = (ext_y[2] + (ext_y[5] <<< 1) + ext_y[8])
           - (ext_y[0] + (ext_y[3] <<< 1) + ext_y[6]);
      gy_c = (ext_y[6] + (ext_y[7] <<< 1) + ext_y[8])
           - (ext_y[0] + (ext_y[1] <<< 1) + ext_y[2]);
   end

   // Stage 2: gradient registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         s2_valid <= 1'b0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_mode  <= s1_mode;
         s2_gx    <= gx_c;
         s2_gy    <= gy_c;
      end
   end

   // Squares are taken on magnitudes so the products stay unsigned and exact
   always_comb begin
      abs_x = s2_gx[G_W-1] ? G_W'(-s2_gx) : G_W'(s2_gx);
      abs_y = s2_gy[G_W-1] ? G_W'(-s2_gy) : G_W'(s2_gy);
      sq_x  = MAG_W'(abs_x) * MAG_W'(abs_x);
      sq_y  = MAG_W'(abs_y) * MAG_W'(abs_y);
      case (s2_mode)
         2'b00:   res = sq_x;
         2'b01:   res = sq_y;
         2'b10:   res = sq_x + sq_y;
         default: res = MAG_W'(abs_x) + MAG_W'(abs_y);
      endcase
   end

   // Stage 3: registered result (and edge flag when enabled)
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         data_out  <= '0;
`ifdef SOBEL_EDGE_THRESH_EN
         edge_out  <= 1'b0;
`endif
      end else if (advance) begin
         out_valid <= s2_valid;
         data_out  <= res;
`ifdef SOBEL_EDGE_THRESH_EN
         edge_out  <= (res >= thresh);
`endif
      end
   end

   // Completed output handshakes, wrapping naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_count <= '0;
      end else if (out_valid && out_ready) begin
         out_count <= out_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_sobel_grad_unit.sv
// tb/tb_sobel_grad_unit.sv - scoreboard bench for sobel_grad_unit with randomized windows and backpressure
module tb_sobel_grad_unit;

   localparam int CH_W  = 8;
   localparam int CNT_W = 4;
   localparam int MAG_W = 2 * CH_W + 13;
   localparam int WIN_W = 27 * CH_W;
   localparam longint THR = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset, in_valid, in_ready, out_valid, out_ready;
   logic [WIN_W-1:0]   in_win;
   logic [1:0]         in_mode;
   logic [MAG_W-1:0]   data_out;
   logic [CNT_W-1:0]   out_count;
`ifdef SOBEL_EDGE_THRESH_EN
   logic [MAG_W-1:0]   thresh;
   logic               edge_out;
`endif

   sobel_grad_unit #(.CH_W(CH_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_win    (in_win),
      .in_mode   (in_mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count)
`ifdef SOBEL_EDGE_THRESH_EN
     ,.thresh    (thresh),
      .edge_out  (edge_out)
`endif
   );

   int      n_checks = 0;
   int      n_fail   = 0;
   longint  exp_q [$];
   int      exp_cnt  = 0;
   logic    prev_stall = 1'b0;
   logic [MAG_W-1:0] prev_data;
   logic [CNT_W-1:0] prev_cnt;
   logic    stress_done;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: Sobel straight from the luma/kernel/measure definitions
   function automatic longint model(input logic [WIN_W-1:0] w, input logic [1:0] m);
      longint y [9];
      longint gx, gy, r, g, b;
      for (int k = 0; k < 9; k++) begin
         r = longint'(w[k*24+16 +: 8]);
         g = longint'(w[k*24+8  +: 8]);
         b = longint'(w[k*24    +: 8]);
         y[k] = 5*r + 9*g + 2*b;
      end
      gx = (y[2] + 2*y[5] + y[8]) - (y[0] + 2*y[3] + y[6]);
      gy = (y[6] + 2*y[7] + y[8]) - (y[0] + 2*y[1] + y[2]);
      case (m)
         2'd0:    return gx*gx;
         2'd1:    return gy*gy;
         2'd2:    return gx*gx + gy*gy;
         default: return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      endcase
   endfunction

   // Gray window with per-column levels
   function automatic logic [WIN_W-1:0] mkwin(input int l, input int c, input int r);
      logic [WIN_W-1:0] w;
      logic [7:0] v;
      for (int k = 0; k < 9; k++) begin
         v = (k % 3 == 0) ? 8'(l) : (k % 3 == 1) ? 8'(c) : 8'(r);
         w[k*24 +: 24] = {v, v, v};
      end
      return w;
   endfunction

   function automatic logic [WIN_W-1:0] rndwin();
      logic [WIN_W-1:0] w;
      for (int k = 0; k < 27; k++) w[k*8 +: 8] = 8'($urandom);
      return w;
   endfunction

   // Scoreboard producer: each accepted window pushes its expected result
   always @(negedge clk) begin
      if (reset && in_valid && in_ready) exp_q.push_back(model(in_win, in_mode));
   end

   // Monitor: pops on every output handshake, checks stall stability
   always @(negedge clk) begin
      longint e;
      if (!reset) begin
         exp_q.delete();
         exp_cnt    = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_data", data_out, prev_data);
            chk("stall_valid", out_valid, 1);
            chk("stall_count", out_count, prev_cnt);
         end
         if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
         if (out_valid && out_ready) begin
            chk("count_at_hs", out_count, exp_cnt);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got %0d, expected no output (t=%0t)", data_out, $time);
            end else begin
               e = exp_q.pop_front();
               chk("data_out", data_out, e);
`ifdef SOBEL_EDGE_THRESH_EN
               chk("edge_out", edge_out, (e >= THR) ? 1 : 0);
`endif
            end
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = data_out;
         prev_cnt   = out_count;
      end
   end

   task automatic send(input logic [WIN_W-1:0] w, input logic [1:0] m);
      bit ok = 0;
      in_win   = w;
      in_mode  = m;
      in_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic single(input logic [WIN_W-1:0] w, input logic [1:0] m,
                         input longint exp, input string nm);
      send(w, m);
      @(negedge clk); chk({nm, "_lat1"}, out_valid, 0);
      @(negedge clk); chk({nm, "_lat2"}, out_valid, 0);
      @(negedge clk); chk({nm, "_valid"}, out_valid, 1);
      chk(nm, data_out, exp);
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) break;
      end
      chk("drain_empty", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_win = '0; in_mode = 2'd0; out_ready = 1'b1;
      stress_done = 1'b0;
`ifdef SOBEL_EDGE_THRESH_EN
      thresh = MAG_W'(THR);
`endif
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      for (int m = 0; m < 4; m++) single(mkwin(128, 128, 128), 2'(m), 0, "uniform");
      single(mkwin(0, 0, 255), 2'd0, 266342400, "edge_m0");
      single(mkwin(0, 0, 255), 2'd1, 0,         "edge_m1");
      single(mkwin(0, 0, 255), 2'd2, 266342400, "edge_m2");
      single(mkwin(0, 0, 255), 2'd3, 16320,     "edge_m3");
      single(mkwin(255, 0, 0), 2'd0, 266342400, "mirror_m0");
      single(mkwin(255, 0, 0), 2'd3, 16320,     "mirror_m3");

      // Backpressure: six windows, out_ready low for five cycles mid-stream
      pulse_reset();
      fork
         begin
            for (int i = 0; i < 6; i++) send(rndwin(), 2'(i % 4));
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("count_after_stall", out_count, 6);

      // Reset with three windows in flight
      for (int i = 0; i < 3; i++) send(rndwin(), 2'(i));
      pulse_reset();
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_count", out_count, 0);
      repeat (10) @(posedge clk);
      #1;

      // Counter wrap over 17 handshakes
      for (int i = 0; i < 17; i++) send(rndwin(), 2'($urandom_range(0, 3)));
      drain();
      chk("count_wrap", out_count, 1);

      // Random stress with random gaps and random backpressure
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               int gap;
               send(rndwin(), 2'($urandom_range(0, 3)));
               gap = $urandom_range(0, 2);
               if (gap > 0) begin
                  repeat (gap) @(posedge clk);
                  #1;
               end
            end
            stress_done = 1'b1;
         end
         begin
            while (!stress_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
